bbt_eval_ctrl: RTL and testbench

Synchronous evaluation controller that drives the 64-stage bistable-ring PUF (`bbt`) and collects its responses. It generates challenges from an internal LFSR, pulses the ring reset, waits for the ring to settle, and samples the ring output through a synchronizer. It then majority-votes repeated evaluations and packs the response bits into words delivered over a valid/ready handshake. It sits between the ring instance and the host-side response logic.

---
 rtl/bbt_pkg.sv | 8 +
 rtl/bbt_lfsr.sv | 20 ++
 rtl/bbt_eval_ctrl.sv | 122 ++++++++++++
 tb/tb_bbt_eval_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bbt_pkg.sv
// Shared types and constants for the bistable-ring PUF evaluation controller.
package bbt_pkg;
  localparam int          BBT_CHAL_W        = 64;
  localparam logic [63:0] BBT_LFSR_TAPS     = 64'hD800_0000_0000_0000;
  localparam logic [63:0] BBT_ZERO_SEED_SUB = 64'h1;

  typedef enum logic [1:0] {IDLE, RST, SETTLE, OUT} bbt_state_e;
endpackage

// File: rtl/bbt_lfsr.sv
// 64-bit Fibonacci challenge LFSR (x^64+x^63+x^61+x^60+1), shifting toward the MSB.
module bbt_lfsr
  import bbt_pkg::*;
#(
  parameter logic [BBT_CHAL_W-1:0] SEED = 64'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BBT_CHAL_W-1:0] load_val,
  input  logic                  step,
  output logic [BBT_CHAL_W-1:0] state
);
  // An all-zero state would lock the LFSR, so a zero load is substituted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      state <= SEED;
    else if (load) state <= (load_val == '0) ? BBT_ZERO_SEED_SUB : load_val;
    else if (step) state <= {state[BBT_CHAL_W-2:0], ^(state & BBT_LFSR_TAPS)};
  end
endmodule

// File: rtl/bbt_eval_ctrl.sv
// Evaluation controller for the bistable-ring PUF: reset/settle/sample sequencing and word packing.
// BBT_MAJORITY_VOTE_EN enables VOTES evaluations per bit with majority resolution.
module bbt_eval_ctrl
  import bbt_pkg::*;
#(
  parameter int                    RESP_W     = 32,
  parameter int                    VOTES      = 5,
  parameter int                    RST_CYC    = 4,
  parameter int                    SETTLE_CYC = 64,
  parameter logic [BBT_CHAL_W-1:0] LFSR_SEED  = 64'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  seed_load,
  input  logic [BBT_CHAL_W-1:0] seed,
  input  logic                  p_bit,
  output logic [BBT_CHAL_W-1:0] ring_chal,
  output logic                  ring_rst,
  output logic                  busy,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RESP_W-1:0]     resp_data
);
  localparam int CW = $clog2(RST_CYC + SETTLE_CYC + 1);
  localparam int BW = $clog2(RESP_W + 1);

  bbt_state_e    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [RESP_W-1:0] sr;
  logic          s1, s2;
  logic          settle_last, last_vote, bit_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= p_bit;
      s2 <= s1;
    end
  end

  assign settle_last = (state == SETTLE) && (cnt == CW'(SETTLE_CYC - 1));

`ifdef BBT_MAJORITY_VOTE_EN
  logic [3:0] votes, ones, votes_nx, ones_nx;
  always_comb begin
    votes_nx  = votes + 4'd1;
    ones_nx   = ones + {3'b0, s2};
    last_vote = (votes_nx == 4'(VOTES));
    bit_val   = (ones_nx > 4'(VOTES / 2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      votes <= '0;
      ones  <= '0;
    end else if (settle_last) begin
      votes <= last_vote ? 4'd0 : votes_nx;
      ones  <= last_vote ? 4'd0 : ones_nx;
    end
  end
`else
  always_comb begin
    last_vote = 1'b1;
    bit_val   = s2;
  end
`endif

  bbt_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == IDLE) && seed_load),
    .load_val (seed),
    .step     (settle_last && last_vote),
    .state    (ring_chal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      case (state)
        IDLE: if (start && !seed_load) begin
          state   <= RST;
          cnt     <= '0;
          bit_idx <= '0;
        end
        RST: begin
          if (cnt == CW'(RST_CYC - 1)) begin
            state <= SETTLE;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        SETTLE: begin
          if (settle_last) begin
            cnt   <= '0;
            state <= RST;
            if (last_vote) begin
              for (int i = 0; i < RESP_W; i++)
                if (bit_idx == BW'(i)) sr[i] <= bit_val;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BW'(RESP_W - 1)) state <= OUT;
            end
          end else cnt <= cnt + 1'b1;
        end
        OUT: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ring_rst   = (state != SETTLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == OUT);
  assign resp_data  = sr;
endmodule

// File: tb/tb_bbt_eval_ctrl.sv
// Directed self-checking bench for bbt_eval_ctrl (RESP_W=8, VOTES=3, RST_CYC=4, SETTLE_CYC=8).
module tb_bbt_eval_ctrl;
`ifdef BBT_MAJORITY_VOTE_EN
  localparam int EVALS = 3;
`else
  localparam int EVALS = 1;
`endif
  localparam int LAT = 1 + 8 * EVALS * 12;
  localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, seed_load = 1'b0, resp_ready = 1'b0;
  logic [63:0] seed = '0;
  logic        p_bit;
  logic [63:0] ring_chal;
  logic        ring_rst, busy, resp_valid;
  logic [7:0]  resp_data;

  int tests = 0, fails = 0;
  int pmode = 1;
  int evals = 0;

  bbt_eval_ctrl #(.RESP_W(8), .VOTES(3), .RST_CYC(4), .SETTLE_CYC(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed(seed),
    .p_bit(p_bit), .ring_chal(ring_chal), .ring_rst(ring_rst), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Ring model: each falling ring_rst begins a new evaluation.
  always @(negedge ring_rst) evals++;
  assign p_bit = (pmode == 0) ? 1'b0 :
                 (pmode == 1) ? 1'b1 :
                 (pmode == 2) ? ^ring_chal : ((evals % 3) != 2);

  function automatic logic [63:0] lfsr_nx(input logic [63:0] m);
    return {m[62:0], ^(m & TAPS)};
  endfunction

  task automatic run_word(output logic [7:0] d, output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    d = resp_data;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests += 5;
    if (ring_rst !== 1'b1) begin fails++; $display("FAIL reset_ring_rst got %b exp 1", ring_rst); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    if (resp_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", resp_data); end
    if (ring_chal !== 64'h1) begin fails++; $display("FAIL reset_chal got %h exp 1", ring_chal); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_seed();
    seed = 64'h5; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    tests++;
    if (ring_chal !== 64'h5) begin fails++; $display("FAIL seed_load got %h exp 5", ring_chal); end
    seed = 64'h0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    tests++;
    if (ring_chal !== 64'h1) begin fails++; $display("FAIL seed_zero got %h exp 1", ring_chal); end
    seed = 64'hDEAD_BEEF_1234_5678; seed_load = 1'b1; start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
    tests += 2;
    if (ring_chal !== 64'hDEAD_BEEF_1234_5678) begin fails++; $display("FAIL seed_start_chal got %h exp deadbeef12345678", ring_chal); end
    if (busy !== 1'b0) begin fails++; $display("FAIL seed_start_busy got %b exp 0", busy); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL seed_start_busy2 got %b exp 0", busy); end
  endtask

  task automatic test_const();
    logic [7:0] d;
    int lat;
    pmode = 1;
    run_word(d, lat);
    tests += 2;
    if (lat !== LAT) begin fails++; $display("FAIL const1_latency got %0d exp %0d", lat, LAT); end
    if (d !== 8'hFF) begin fails++; $display("FAIL const1_data got %h exp ff", d); end
    ack();
    tests++;
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL const1_valid_drop got %b exp 0", resp_valid); end
    pmode = 0;
    run_word(d, lat);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL const0_data got %h exp 00", d); end
    ack();
  endtask

  task automatic test_parity();
    logic [7:0] d, e;
    logic [63:0] m;
    int lat;
    seed = 64'h1; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    pmode = 2;
    m = 64'h1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        e[i] = ^m;
        m = lfsr_nx(m);
      end
      run_word(d, lat);
      tests++;
      if (d !== e) begin fails++; $display("FAIL parity_word%0d got %h exp %h", w, d, e); end
      ack();
    end
    tests++;
    if (ring_chal !== m) begin fails++; $display("FAIL parity_chal got %h exp %h", ring_chal, m); end
  endtask

  task automatic test_majority();
    logic [7:0] d;
    int lat;
    evals = 0;
`ifdef BBT_MAJORITY_VOTE_EN
    pmode = 3;
`else
    pmode = 1;
`endif
    run_word(d, lat);
    tests += 2;
    if (lat !== LAT) begin fails++; $display("FAIL majority_latency got %0d exp %0d", lat, LAT); end
    if (d !== 8'hFF) begin fails++; $display("FAIL majority_data got %h exp ff", d); end
    ack();
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int lat;
    bit bad = 0;
    pmode = 2;
    run_word(d, lat);
    for (int c = 0; c < 50; c++) begin
      start = (c == 10);
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d) bad = 1;
    end
    start = 1'b0;
    tests++;
    if (bad) begin fails++; $display("FAIL backpressure_hold valid %b data %h exp 1 %h", resp_valid, resp_data, d); end
    ack();
    tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL backpressure_release valid %b busy %b exp 0 0", resp_valid, busy); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_in_out_queued busy %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    pmode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * EVALS * 12 + 6) @(negedge clk);
    rst = 1'b0;
    #1;
    tests += 5;
    if (ring_rst !== 1'b1) begin fails++; $display("FAIL mid_ring_rst got %b exp 1", ring_rst); end
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy); end
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", resp_valid); end
    if (ring_chal !== 64'h1) begin fails++; $display("FAIL mid_chal got %h exp 1", ring_chal); end
    if (resp_data !== 8'h00) begin fails++; $display("FAIL mid_data got %h exp 00", resp_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < LAT + 20; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL mid_no_word got activity exp none"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_seed();
    test_const();
    test_parity();
    test_majority();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
